// File: rtl/demux_user_sequencer.sv
// -----------------------------------------------------------------------------
// demux_user_sequencer
//
// Upstream sequencer for the per-user data array stage. A programmable
// per-user length table is walked in index order on every symbol trigger.
// Each user gets a one-cycle start pulse, a valid/ready handshaked run of
// data beats, a one-cycle end pulse and a fixed guard gap of GAP_CYC cycles.
//
// Optional feature macro: DEMUX_ZERO_LEN_SKIP_EN
//   defined   : zero-length users are skipped in SEEK with no start/end pulses
//   undefined : zero-length users still get START -> END -> GAP (no data beats)
//
// Ports
//   i_core_clk          core clock
//   i_rx_rstn           asynchronous active-low reset (clears FSM and table)
//   i_cfg_wr_en         length-table write strobe
//   i_cfg_wr_idx        table entry to write (idx >= USER_NUM is dropped)
//   i_cfg_wr_len        beat count for that entry
//   i_sym_start         one-cycle pulse that begins a pass
//   i_user_num          users in the pass, sampled with i_sym_start
//   i_data_ready        downstream accepts the current beat
//   o_demux_user_start  one-cycle pulse per user
//   o_demux_user_end    one-cycle pulse per user
//   o_demux_user_idx    current user index
//   o_demux_data_vld    data beat valid
//   o_demux_data_cnt    index of the current beat within the user
//   o_sym_busy          pass in progress
//   o_sym_done          one-cycle pulse at end of pass
//   o_sym_overrun       one-cycle pulse after i_sym_start arrives while busy
// -----------------------------------------------------------------------------
module demux_user_sequencer #(
  parameter int USER_NUM = 40,
  parameter int IDX_W    = 6,
  parameter int LEN_W    = 12,
  parameter int GAP_CYC  = 4
) (
  input  logic             i_core_clk,
  input  logic             i_rx_rstn,
  input  logic             i_cfg_wr_en,
  input  logic [IDX_W-1:0] i_cfg_wr_idx,
  input  logic [LEN_W-1:0] i_cfg_wr_len,
  input  logic             i_sym_start,
  input  logic [IDX_W-1:0] i_user_num,
  input  logic             i_data_ready,
  output logic             o_demux_user_start,
  output logic             o_demux_user_end,
  output logic [IDX_W-1:0] o_demux_user_idx,
  output logic             o_demux_data_vld,
  output logic [LEN_W-1:0] o_demux_data_cnt,
  output logic             o_sym_busy,
  output logic             o_sym_done,
  output logic             o_sym_overrun
);

  // One extra bit so that a pass of exactly 2^IDX_W users is representable.
  localparam int NUM_W = IDX_W + 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [NUM_W-1:0] USER_NUM_C = NUM_W'(USER_NUM);
  localparam logic [GAP_W-1:0] GAP_LAST_C = GAP_W'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEEK  = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_END   = 3'd4,
    S_GAP   = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_tab_q [USER_NUM];
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic             start_q;
  logic             end_q;
  logic             vld_q;
  logic             busy_q;
  logic             done_q;
  logic             overrun_q;

  logic [LEN_W-1:0] seek_len_s;
  logic [NUM_W-1:0] num_req_s;
  logic             last_user_s;

  // Length table; a write to an index outside the table matches no entry.
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      for (int i = 0; i < USER_NUM; i++) begin
        len_tab_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < USER_NUM; i++) begin
        if (i_cfg_wr_en && (i_cfg_wr_idx == IDX_W'(i))) begin
          len_tab_q[i] <= i_cfg_wr_len;
        end
      end
    end
  end

  // Table read port: AND-OR select of the entry addressed by the user index.
  // The read sees the registered table, so a same-cycle write is not visible.
  always_comb begin
    seek_len_s = '0;
    for (int i = 0; i < USER_NUM; i++) begin
      seek_len_s = seek_len_s | (len_tab_q[i] & {LEN_W{idx_q == IDX_W'(i)}});
    end
  end

  // Pass size clamped to the table depth, and last-user detection.
  always_comb begin
    num_req_s   = (NUM_W'(i_user_num) > USER_NUM_C) ? USER_NUM_C : NUM_W'(i_user_num);
    last_user_s = ((NUM_W'(idx_q) + NUM_W'(1)) == num_q);
  end

  // Next-state logic; the user index only moves on edges that enter SEEK.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    num_d   = num_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (i_sym_start) begin
          num_d = num_req_s;
          if (num_req_s == '0) begin
            state_d = S_DONE;
          end else begin
            idx_d   = '0;
            state_d = S_SEEK;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEEK: begin
        // Latch the length so later table writes cannot disturb this user.
        len_d = seek_len_s;
        if (seek_len_s != '0) begin
          cnt_d   = '0;
          state_d = S_START;
        end else begin
`ifdef DEMUX_ZERO_LEN_SKIP_EN
          if (last_user_s) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_SEEK;
          end
`else
          cnt_d   = '0;
          state_d = S_START;
`endif
        end
      end
      S_START: begin
        if (len_q == '0) begin
          state_d = S_END;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (i_data_ready) begin
          // The count stops at len-1; the final transfer leaves DATA instead.
          if (cnt_q == (len_q - LEN_W'(1))) begin
            state_d = S_END;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_END: begin
        gap_d   = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_q == GAP_LAST_C) begin
          if (last_user_s) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_SEEK;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; strobes are decoded from the next state so
  // they line up with the state register they describe.
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      num_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      start_q   <= 1'b0;
      end_q     <= 1'b0;
      vld_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      num_q     <= num_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      start_q   <= (state_d == S_START);
      end_q     <= (state_d == S_END);
      vld_q     <= (state_d == S_DATA);
      busy_q    <= (state_d != S_IDLE);
      done_q    <= (state_d == S_DONE);
      overrun_q <= i_sym_start && (state_q != S_IDLE);
    end
  end

  assign o_demux_user_start = start_q;
  assign o_demux_user_end   = end_q;
  assign o_demux_user_idx   = idx_q;
  assign o_demux_data_vld   = vld_q;
  assign o_demux_data_cnt   = cnt_q;
  assign o_sym_busy         = busy_q;
  assign o_sym_done         = done_q;
  assign o_sym_overrun      = overrun_q;

endmodule

// File: tb/tb_demux_user_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for demux_user_sequencer (default parameters, GAP_CYC = 4).
// A pass-level schedule model builds the expected cycle-by-cycle outputs from
// the table contents and the pre-generated ready pattern; a vector table adds
// hand-computed pass timings, and directed sequences cover overrun, zero-length
// users, mid-pass writes, clamping and reset during a pass.
// -----------------------------------------------------------------------------
module tb_demux_user_sequencer;

  localparam int USER_NUM = 40;
  localparam int IDX_W    = 6;
  localparam int LEN_W    = 12;
  localparam int GAP_CYC  = 4;
  localparam int MAXC     = 2048;

  logic             clk       = 1'b0;
  logic             rstn      = 1'b0;
  logic             wr_en     = 1'b0;
  logic [IDX_W-1:0] wr_idx    = '0;
  logic [LEN_W-1:0] wr_len    = '0;
  logic             sym_start = 1'b0;
  logic [IDX_W-1:0] user_num  = '0;
  logic             ready     = 1'b0;
  logic             u_start, u_end, vld, busy, done, ovr;
  logic [IDX_W-1:0] u_idx;
  logic [LEN_W-1:0] cnt;

  always #5 clk = ~clk;

  demux_user_sequencer #(
    .USER_NUM(USER_NUM), .IDX_W(IDX_W), .LEN_W(LEN_W), .GAP_CYC(GAP_CYC)
  ) dut (
    .i_core_clk        (clk),
    .i_rx_rstn         (rstn),
    .i_cfg_wr_en       (wr_en),
    .i_cfg_wr_idx      (wr_idx),
    .i_cfg_wr_len      (wr_len),
    .i_sym_start       (sym_start),
    .i_user_num        (user_num),
    .i_data_ready      (ready),
    .o_demux_user_start(u_start),
    .o_demux_user_end  (u_end),
    .o_demux_user_idx  (u_idx),
    .o_demux_data_vld  (vld),
    .o_demux_data_cnt  (cnt),
    .o_sym_busy        (busy),
    .o_sym_done        (done),
    .o_sym_overrun     (ovr)
  );

  typedef struct packed {
    logic             st;
    logic             en;
    logic             vld;
    logic             busy;
    logic             done;
    logic             ovr;
    logic [IDX_W-1:0] idx;
    logic [LEN_W-1:0] cnt;
  } obs_t;

  typedef struct {
    int user_num;
    int stall_at;
    int stall_len;
    int e_done;
    int e_starts;
    int e_beats;
    int e_start0;
    int e_end0;
    int e_start1;
  } vec_t;

  obs_t expq [MAXC];
  bit   rdy  [MAXC];
  int   exp_len;
  int   mtab [USER_NUM];
  int   m_idx = 0;
  int   m_cnt = 0;
  int   checks = 0;
  int   failures = 0;
  int   r_done, r_starts, r_beats;
  int   r_start_cyc [$];
  int   r_end_cyc   [$];

  initial begin
    #2000000;
    $display("FAIL watchdog: got no summary before time limit, need TB_RESULT line");
    $fatal(1, "watchdog expired");
  end

  task automatic check_int(input string name, input int got, input int need);
    checks++;
    if (got != need) begin
      failures++;
      $display("FAIL %s: got %0d, need %0d", name, got, need);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({u_start, u_end, vld, busy, done, ovr, u_idx, cnt} !== '0) begin
      failures++;
      $display("FAIL %s: outputs not all zero st=%0b en=%0b vld=%0b busy=%0b done=%0b ovr=%0b idx=%0d cnt=%0d",
               name, u_start, u_end, vld, busy, done, ovr, u_idx, cnt);
    end
  endtask

  task automatic cmp_cycle(input int k);
    obs_t a;
    a.st = u_start; a.en = u_end; a.vld = vld; a.busy = busy;
    a.done = done;  a.ovr = ovr;  a.idx = u_idx; a.cnt = cnt;
    checks++;
    if (a !== expq[k]) begin
      failures++;
      $display("FAIL cycle T+%0d: got st=%0b en=%0b vld=%0b busy=%0b done=%0b ovr=%0b idx=%0d cnt=%0d, need st=%0b en=%0b vld=%0b busy=%0b done=%0b ovr=%0b idx=%0d cnt=%0d",
               k, a.st, a.en, a.vld, a.busy, a.done, a.ovr, a.idx, a.cnt,
               expq[k].st, expq[k].en, expq[k].vld, expq[k].busy, expq[k].done,
               expq[k].ovr, expq[k].idx, expq[k].cnt);
    end
  endtask

  // Append one expected cycle using the currently held idx/cnt values.
  function automatic void put(inout int k, input bit st, input bit en, input bit v,
                              input bit dn, input bit bz);
    if (k < MAXC) begin
      expq[k].st   = st;
      expq[k].en   = en;
      expq[k].vld  = v;
      expq[k].busy = bz;
      expq[k].done = dn;
      expq[k].ovr  = 1'b0;
      expq[k].idx  = IDX_W'(m_idx);
      expq[k].cnt  = LEN_W'(m_cnt);
    end
    k++;
  endfunction

  // Expected trace of one pass, cycle 0 = cycle in which the trigger is sampled.
  function automatic void build(input int req);
    int k;
    int num;
    int len;
    num = (req > USER_NUM) ? USER_NUM : req;
    k = 1;
    for (int u = 0; u < num; u++) begin
      len   = mtab[u];
      m_idx = u;
      put(k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef DEMUX_ZERO_LEN_SKIP_EN
      if (len == 0) continue;
`endif
      m_cnt = 0;
      put(k, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int b = 0; b < len; b++) begin
        m_cnt = b;
        while (k < MAXC - 1 && !rdy[k]) put(k, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        put(k, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      end
      put(k, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int g = 0; g < GAP_CYC; g++) put(k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    put(k, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    put(k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_len = (k < MAXC) ? k : MAXC;
  endfunction

  task automatic fill_rdy(input int stall_at, input int stall_len, input int rand_pct);
    for (int j = 0; j < MAXC; j++) begin
      rdy[j] = (rand_pct > 0) ? ($urandom_range(99, 0) < rand_pct) : 1'b1;
      if (j >= stall_at && j < stall_at + stall_len) rdy[j] = 1'b0;
    end
  endtask

  task automatic wr(input int idx, input int len);
    @(negedge clk);
    wr_en  = 1'b1;
    wr_idx = IDX_W'(idx);
    wr_len = LEN_W'(len);
    if (idx < USER_NUM) mtab[idx] = len;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic run_pass(input int req, input int ov_at, input int wr_at, input int w_idx,
                          input int w_len, input int abort_idx);
    int abort_k;
    build(req);
    if (ov_at > 0 && ov_at + 1 < exp_len) expq[ov_at + 1].ovr = 1'b1;
    abort_k = -1;
    if (abort_idx >= 0) begin
      for (int k = 1; k < exp_len; k++) begin
        if (abort_k < 0 && expq[k].vld && expq[k].idx == IDX_W'(abort_idx)) abort_k = k;
      end
    end
    r_done = -1; r_starts = 0; r_beats = 0;
    r_start_cyc.delete(); r_end_cyc.delete();
    @(negedge clk);
    sym_start = 1'b1;
    user_num  = IDX_W'(req);
    ready     = rdy[0];
    for (int k = 1; k < exp_len; k++) begin
      @(negedge clk);
      cmp_cycle(k);
      if (u_start) begin r_starts++; r_start_cyc.push_back(k); end
      if (u_end) r_end_cyc.push_back(k);
      if (done && r_done < 0) r_done = k;
      sym_start = (k == ov_at);
      wr_en     = (k == wr_at);
      wr_idx    = IDX_W'(w_idx);
      wr_len    = LEN_W'(w_len);
      ready     = rdy[k];
      if (vld && ready) r_beats++;
      if (k == abort_k) begin
        sym_start = 1'b0;
        wr_en     = 1'b0;
        rstn      = 1'b0;
        #1;
        check_zero("reset_mid_pass");
        @(negedge clk);
        check_zero("held_in_reset");
        rstn = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check_zero("idle_after_reset_no_end");
        end
        m_idx = 0;
        m_cnt = 0;
        foreach (mtab[i]) mtab[i] = 0;
        break;
      end
    end
    sym_start = 1'b0;
    wr_en     = 1'b0;
    ready     = 1'b0;
  endtask

  initial begin
    vec_t vt [5];
    int   e_starts;
    int   e_done;
    int   q;

    vt[0] = '{2, 0, 0, 20, 2, 5, 2,  6, 12};
    vt[1] = '{2, 4, 2, 22, 2, 5, 2,  8, 14};
    vt[2] = '{1, 0, 0, 11, 1, 3, 2,  6, -1};
    vt[3] = '{0, 0, 0,  1, 0, 0, -1, -1, -1};
    vt[4] = '{1, 3, 1, 12, 1, 3, 2,  7, -1};
    foreach (mtab[i]) mtab[i] = 0;

    repeat (2) @(negedge clk);
    check_zero("reset_state");
    rstn = 1'b1;
    @(negedge clk);
    check_zero("idle_after_release");

    // Vector table: len[0]=3, len[1]=2.
    wr(0, 3);
    wr(1, 2);
    for (int i = 0; i < 5; i++) begin
      fill_rdy(vt[i].stall_at, vt[i].stall_len, 0);
      run_pass(vt[i].user_num, 0, -1, 0, 0, -1);
      check_int("vec_done_cycle", r_done, vt[i].e_done);
      check_int("vec_starts", r_starts, vt[i].e_starts);
      check_int("vec_beats", r_beats, vt[i].e_beats);
      check_int("vec_start0", (r_start_cyc.size() > 0) ? r_start_cyc[0] : -1, vt[i].e_start0);
      check_int("vec_end0", (r_end_cyc.size() > 0) ? r_end_cyc[0] : -1, vt[i].e_end0);
      check_int("vec_start1", (r_start_cyc.size() > 1) ? r_start_cyc[1] : -1, vt[i].e_start1);
    end

    // Overrun: second trigger mid-pass leaves the pass unchanged.
    fill_rdy(0, 0, 0);
    run_pass(2, 5, -1, 0, 0, -1);
    check_int("overrun_pass_done", r_done, 20);
    check_int("overrun_pass_starts", r_starts, 2);

    // Zero-length user 5 between one-beat users.
    for (int i = 0; i < 5; i++) wr(i, 1);
    wr(5, 0);
    wr(6, 1);
`ifdef DEMUX_ZERO_LEN_SKIP_EN
    e_starts = 6;
    e_done   = 50;
`else
    e_starts = 7;
    e_done   = 56;
`endif
    run_pass(7, 0, -1, 0, 0, -1);
    check_int("zero_len_starts", r_starts, e_starts);
    check_int("zero_len_done", r_done, e_done);
    check_int("zero_len_beats", r_beats, 6);

    // Mid-pass write to user 2 while user 1 is in DATA (cycle 13).
    wr(0, 3);
    wr(1, 2);
    wr(2, 1);
    mtab[2] = 4;
    run_pass(3, 0, 13, 2, 4, -1);
    check_int("midpass_write_beats", r_beats, 9);
    check_int("midpass_write_done", r_done, 31);
    // Write to user 2 in its own SEEK cycle (20): the read keeps the old value.
    run_pass(3, 0, 20, 2, 7, -1);
    check_int("seek_same_cycle_write_beats", r_beats, 9);
    mtab[2] = 7;
    run_pass(3, 0, -1, 0, 0, -1);
    check_int("seek_write_took_effect_beats", r_beats, 12);

    // Clamp: 63 requested, 40 one-beat users run; out-of-range write dropped.
    for (int i = 0; i < USER_NUM; i++) wr(i, 1);
    wr(45, 9);
    run_pass(63, 0, -1, 0, 0, -1);
    check_int("clamp_starts", r_starts, 40);
    check_int("clamp_beats", r_beats, 40);
    check_int("clamp_done", r_done, 321);

    // Reset during DATA of user 3, then a pass over the cleared table.
    for (int i = 0; i < 5; i++) wr(i, 2);
    run_pass(5, 0, -1, 0, 0, 3);
`ifdef DEMUX_ZERO_LEN_SKIP_EN
    e_starts = 0;
`else
    e_starts = 4;
`endif
    run_pass(4, 0, -1, 0, 0, -1);
    check_int("after_reset_starts", r_starts, e_starts);
    check_int("after_reset_beats", r_beats, 0);

    // Randomized passes against the schedule model.
    for (int p = 0; p < 8; p++) begin
      for (int w = 0; w < 4; w++) wr($urandom_range(11, 0), $urandom_range(5, 0));
      fill_rdy(0, 0, 70);
      q = $urandom_range(10, 0);
      run_pass(q, (p % 3 == 0) ? $urandom_range(8, 1) : 0, -1, 0, 0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
